// File: rtl/evo_evaluator.sv
// Truth-table evaluator: sweeps every stimulus value into an external circuit, waits for it to
// settle, samples its synchronised output and scores the result against an expected table.
module evo_evaluator #(
  parameter int NUM_INPUTS    = 2,
  parameter int SETTLE_CYCLES = 16,
  parameter int NUM_SAMPLES   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [2**NUM_INPUTS-1:0]   expected,
  output logic [NUM_INPUTS-1:0]      dut_in,
  input  logic                       dut_out,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [NUM_INPUTS:0]        mismatch_count,
  output logic [NUM_INPUTS:0]        unstable_count,
  output logic [2**NUM_INPUTS-1:0]   result_vector
);

  localparam int CMAX = (SETTLE_CYCLES > NUM_SAMPLES) ? SETTLE_CYCLES : NUM_SAMPLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0]         CNT_ONE    = CW'(1);
  localparam logic [CW-1:0]         CNT_SETTLE = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0]         CNT_SAMPLE = CW'(NUM_SAMPLES);
  localparam logic [NUM_INPUTS:0]   SCORE_ONE  = (NUM_INPUTS + 1)'(1);
  localparam logic [NUM_INPUTS-1:0] DIN_ONE    = NUM_INPUTS'(1);
  localparam logic [NUM_INPUTS-1:0] DIN_LAST   = {NUM_INPUTS{1'b1}};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    SAMPLE = 3'd2,
    NEXT   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t                    state_r;
  logic [CW-1:0]             cnt_r;
  logic [1:0]                sync_r;
  logic [2**NUM_INPUTS-1:0]  expected_r;
  logic                      first_r;
  logic                      last_r;
  logic                      unstable_r;
  logic                      samp_s;
  logic [NUM_INPUTS:0]       mismatch_next_s;
  logic [NUM_INPUTS:0]       unstable_next_s;

  assign samp_s = sync_r[1];

  // Two-flop synchroniser for the asynchronous circuit output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], dut_out};
    end
  end

  // Score of the vector currently being retired, so pass can be decided in the same edge
  always_comb begin
    mismatch_next_s = mismatch_count;
    unstable_next_s = unstable_count;
    if (unstable_r) begin
      unstable_next_s = unstable_count + SCORE_ONE;
    end else if (last_r != expected_r[dut_in]) begin
      mismatch_next_s = mismatch_count + SCORE_ONE;
    end else begin
      mismatch_next_s = mismatch_count;
    end
  end

  // Sweep sequencer; every output is a register written only here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      cnt_r          <= '0;
      expected_r     <= '0;
      first_r        <= 1'b0;
      last_r         <= 1'b0;
      unstable_r     <= 1'b0;
      dut_in         <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      mismatch_count <= '0;
      unstable_count <= '0;
      result_vector  <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            expected_r     <= expected;
            mismatch_count <= '0;
            unstable_count <= '0;
            result_vector  <= '0;
            pass           <= 1'b0;
            dut_in         <= '0;
            cnt_r          <= CNT_SETTLE;
            busy           <= 1'b1;
            state_r        <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt_r == CNT_ONE) begin
            cnt_r   <= CNT_SAMPLE;
            state_r <= SAMPLE;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        SAMPLE: begin
          last_r <= samp_s;
          // The first sample is the reference every later sample is held against
          if (cnt_r == CNT_SAMPLE) begin
            first_r    <= samp_s;
            unstable_r <= 1'b0;
          end else if (samp_s != first_r) begin
            unstable_r <= 1'b1;
          end
          if (cnt_r == CNT_ONE) begin
            state_r <= NEXT;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        NEXT: begin
          result_vector[dut_in] <= last_r;
          mismatch_count        <= mismatch_next_s;
          unstable_count        <= unstable_next_s;
          if (dut_in == DIN_LAST) begin
            done    <= 1'b1;
            pass    <= (mismatch_next_s == '0) && (unstable_next_s == '0);
            state_r <= DONE;
          end else begin
            dut_in  <= dut_in + DIN_ONE;
            cnt_r   <= CNT_SETTLE;
            state_r <= SETTLE;
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_evo_evaluator.sv
// Scoreboard bench: two evaluator instances (2 and 3 inputs) sweep behavioural circuits; a
// reference model queues expected results and per-instance monitors check them on each done.
module tb_evo_evaluator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic tog = 1'b0;
  always @(posedge clk) tog <= ~tog;

  // Instance A: 2 inputs, settle 4, samples 4
  logic       start_a = 1'b0;
  logic [3:0] expected_a = 4'h0;
  logic [1:0] dut_in_a;
  logic       dut_out_a;
  logic       busy_a, done_a, pass_a;
  logic [2:0] mc_a, uc_a;
  logic [3:0] rv_a;
  logic       nand_a = 1'b1;
  logic       unst_a = 1'b0;
  logic [3:0] tt_a = 4'h0;

  // Instance B: 3 inputs, settle 3, samples 2
  logic       start_b = 1'b0;
  logic [7:0] expected_b = 8'h00;
  logic [2:0] dut_in_b;
  logic       dut_out_b;
  logic       busy_b, done_b, pass_b;
  logic [3:0] mc_b, uc_b;
  logic [7:0] rv_b;
  logic [7:0] tt_b = 8'h00;

  always_comb begin
    if (unst_a && dut_in_a == 2'd3) dut_out_a = tog;
    else if (nand_a)                dut_out_a = ~(dut_in_a[1] & dut_in_a[0]);
    else                            dut_out_a = tt_a[dut_in_a];
  end
  assign dut_out_b = tt_b[dut_in_b];

  evo_evaluator #(.NUM_INPUTS(2), .SETTLE_CYCLES(4), .NUM_SAMPLES(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .expected(expected_a),
    .dut_in(dut_in_a), .dut_out(dut_out_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .mismatch_count(mc_a), .unstable_count(uc_a), .result_vector(rv_a));

  evo_evaluator #(.NUM_INPUTS(3), .SETTLE_CYCLES(3), .NUM_SAMPLES(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .expected(expected_b),
    .dut_in(dut_in_b), .dut_out(dut_out_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .mismatch_count(mc_b), .unstable_count(uc_b), .result_vector(rv_b));

  typedef struct {
    int unsigned due;
    logic        pass;
    int unsigned mc;
    int unsigned uc;
    logic [7:0]  rv;
    logic [7:0]  mask;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb, last_a;

  int total = 0;
  int bad = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: the circuit's truth table tt, optionally one vector that never holds still
  function automatic exp_t model(int ni, int s, int m, int unsigned acc,
                                 logic [7:0] tt, logic [7:0] ex, int unstable_k);
    exp_t e;
    int nv = 1 << ni;
    e.due = acc + nv * (s + m + 1) + 1;
    e.mc = 0; e.uc = 0; e.rv = 8'h00; e.mask = 8'h00;
    for (int k = 0; k < nv; k++) begin
      if (k == unstable_k && m > 1) begin
        e.uc++;
      end else begin
        e.mask[k] = 1'b1;
        e.rv[k] = tt[k];
        if (tt[k] != ex[k]) e.mc++;
      end
    end
    e.pass = (e.mc == 0) && (e.uc == 0);
    return e;
  endfunction

  always @(negedge clk) begin
    if (done_a) begin
      if (qa.size() == 0) chk("unexpected_done_a", 32'd1, 32'd0);
      else begin
        ea = qa.pop_front();
        chk("done_time_a", cyc, ea.due);
        chk("busy_at_done_a", {31'd0, busy_a}, 32'd1);
        chk("pass_a", {31'd0, pass_a}, {31'd0, ea.pass});
        chk("mismatch_a", {29'd0, mc_a}, ea.mc);
        chk("unstable_a", {29'd0, uc_a}, ea.uc);
        chk("result_a", {28'd0, rv_a} & {24'd0, ea.mask}, {24'd0, ea.rv});
        last_a = ea;
      end
    end
  end

  always @(negedge clk) begin
    if (done_b) begin
      if (qb.size() == 0) chk("unexpected_done_b", 32'd1, 32'd0);
      else begin
        eb = qb.pop_front();
        chk("done_time_b", cyc, eb.due);
        chk("pass_b", {31'd0, pass_b}, {31'd0, eb.pass});
        chk("mismatch_b", {28'd0, mc_b}, eb.mc);
        chk("unstable_b", {28'd0, uc_b}, eb.uc);
        chk("result_b", {24'd0, rv_b} & {24'd0, eb.mask}, {24'd0, eb.rv});
      end
    end
  end

  // Issue a sweep on A; expected is scrambled right after acceptance
  task automatic sweep_a(logic [3:0] ex, logic [7:0] tt, int uk);
    @(negedge clk);
    expected_a = ex;
    start_a = 1'b1;
    qa.push_back(model(2, 4, 4, cyc, tt, {4'h0, ex}, uk));
    @(negedge clk);
    start_a = 1'b0;
    expected_a = 4'($urandom);
  endtask

  task automatic sweep_b(logic [7:0] ex);
    @(negedge clk);
    expected_b = ex;
    start_b = 1'b1;
    qb.push_back(model(3, 3, 2, cyc, tt_b, ex, -1));
    @(negedge clk);
    start_b = 1'b0;
    expected_b = 8'($urandom);
  endtask

  task automatic wait_a();
    int i;
    for (i = 0; i < 1000 && qa.size() != 0; i++) @(negedge clk);
    #1;
    if (qa.size() != 0) begin
      chk("timeout_a", 32'd1, 32'd0);
      qa.delete();
    end
  endtask

  task automatic wait_b();
    int i;
    for (i = 0; i < 1000 && qb.size() != 0; i++) @(negedge clk);
    #1;
    if (qb.size() != 0) begin
      chk("timeout_b", 32'd1, 32'd0);
      qb.delete();
    end
  endtask

  task automatic hold_a();
    repeat (6) @(negedge clk);
    chk("hold_busy_a", {31'd0, busy_a}, 32'd0);
    chk("hold_dut_in_a", {30'd0, dut_in_a}, 32'd3);
    chk("hold_pass_a", {31'd0, pass_a}, {31'd0, last_a.pass});
    chk("hold_mismatch_a", {29'd0, mc_a}, last_a.mc);
    chk("hold_unstable_a", {29'd0, uc_a}, last_a.uc);
    chk("hold_result_a", {28'd0, rv_a} & {24'd0, last_a.mask}, {24'd0, last_a.rv});
  endtask

  initial begin
    logic [3:0] ex4;
    int found;
    #2;
    chk("reset_busy", {31'd0, busy_a}, 32'd0);
    chk("reset_done", {31'd0, done_a}, 32'd0);
    chk("reset_pass", {31'd0, pass_a}, 32'd0);
    chk("reset_counts", {26'd0, mc_a, uc_a}, 32'd0);
    chk("reset_result", {24'd0, rv_a, dut_in_a, 2'd0}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // NAND, matching table
    nand_a = 1'b1; unst_a = 1'b0;
    sweep_a(4'b0111, 8'h07, -1);
    wait_a();
    hold_a();

    // NAND against all-ones expectation
    sweep_a(4'b1111, 8'h07, -1);
    wait_a();
    hold_a();

    // Vector 3 toggles every clock
    unst_a = 1'b1;
    sweep_a(4'b0111, 8'h07, 3);
    wait_a();
    unst_a = 1'b0;

    // Reset during settle of vector 2
    sweep_a(4'b0111, 8'h07, -1);
    repeat (19) @(negedge clk);
    chk("mid_dut_in_a", {30'd0, dut_in_a}, 32'd2);
    chk("mid_busy_a", {31'd0, busy_a}, 32'd1);
    rst_n = 1'b0;
    #1;
    qa.delete();
    qb.delete();
    chk("rst_busy_a", {31'd0, busy_a}, 32'd0);
    chk("rst_outs_a", {24'd0, rv_a, mc_a, uc_a, dut_in_a, pass_a, done_a}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    sweep_a(4'b0111, 8'h07, -1);
    wait_a();

    // Extra starts at +5 and during the done cycle are ignored
    sweep_a(4'b0111, 8'h07, -1);
    repeat (4) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      @(negedge clk);
      if (done_a) found = 1;
    end
    chk("saw_done_a", found, 32'd1);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    #1;
    chk("idle_after_done_a", {31'd0, busy_a}, 32'd0);
    repeat (50) @(negedge clk);
    chk("no_restart_a", {31'd0, busy_a}, 32'd0);
    hold_a();

    // Random truth tables on A
    nand_a = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tt_a = 4'($urandom);
      ex4 = (t[0]) ? tt_a : 4'($urandom);
      sweep_a(ex4, {4'h0, tt_a}, -1);
      wait_a();
    end

    // Three-input instance: constant 0, then random tables
    tt_b = 8'h00;
    sweep_b(8'h00);
    wait_b();
    chk("b_const0_pass", {31'd0, pass_b}, 32'd1);
    for (int t = 0; t < 3; t++) begin
      tt_b = 8'($urandom);
      sweep_b((t == 1) ? tt_b : 8'($urandom));
      wait_b();
    end

    repeat (5) @(negedge clk);
    chk("queue_a_empty", qa.size(), 32'd0);
    chk("queue_b_empty", qb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
